ctrl_pipe_unit: RTL and testbench

//  RV32I decode plus control pipeline. Decodes the ID-stage instruction into an 11-bit control

---
 rtl/ctrl_pipe_unit.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ctrl_pipe_unit : RV32I decode + EX/MEM/WB control pipeline with hazards   |
// | Optional macro CTRL_PERF_CNT_EN enables stall/flush/retire counters.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ctrl_pipe_unit #(
  parameter int REG_AW         = 5,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic              clk_I,
  input  logic              rst_I,
  input  logic [31:0]       instr_I,
  input  logic              instrValid_I,
  input  logic              redirect_I,
  input  logic              memStall_I,
  output logic              stall_O,
  output logic              illegal_O,
  output logic [10:0]       exCtrl_O,
  output logic [REG_AW-1:0] exRd_O,
  output logic              exValid_O,
  output logic [10:0]       memCtrl_O,
  output logic [REG_AW-1:0] memRd_O,
  output logic              memValid_O,
  output logic [10:0]       wbCtrl_O,
  output logic [REG_AW-1:0] wbRd_O,
  output logic              wbValid_O,
  output logic [31:0]       stallCnt_O,
  output logic [31:0]       flushCnt_O,
  output logic [31:0]       retireCnt_O
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic [6:0]        opc_w;
  logic [REG_AW-1:0] rd_w, rs1_w, rs2_w;
  logic [10:0]       decCtrl_w;
  logic              known_w, useRs1_w, useRs2_w, idOk_w, hazard_w, bubble_w;

  logic [10:0]       exCtrl_q, memCtrl_q, wbCtrl_q, exCtrl_d;
  logic [REG_AW-1:0] exRd_q, memRd_q, wbRd_q, exRd_d;
  logic              exValid_q, memValid_q, wbValid_q, exValid_d;

  assign opc_w = instr_I[6:0];
  assign rd_w  = REG_AW'(instr_I[11:7]);
  assign rs1_w = REG_AW'(instr_I[19:15]);
  assign rs2_w = REG_AW'(instr_I[24:20]);

  // Bundle layout: {wbSel[1:0], itype, jump, branch, aluOp, srcB, srcA, regWrite, memWrite, memRead}
  always_comb begin
    decCtrl_w = '0;
    known_w   = 1'b1;
    useRs1_w  = 1'b1;
    useRs2_w  = 1'b0;
    case (opc_w)
      OPC_LOAD:   decCtrl_w = 11'b01_0000_10101;
      OPC_STORE:  begin decCtrl_w = 11'b00_0000_10010; useRs2_w = 1'b1; end
      OPC_OP:     begin decCtrl_w = 11'b00_0001_00100; useRs2_w = 1'b1; end
      OPC_OPIMM:  decCtrl_w = 11'b00_1001_10100;
      OPC_BRANCH: begin decCtrl_w = 11'b00_0010_00000; useRs2_w = 1'b1; end
      OPC_JAL:    begin decCtrl_w = 11'b10_0100_11100; useRs1_w = 1'b0; end
      OPC_JALR:   decCtrl_w = 11'b10_0100_10100;
      OPC_LUI:    begin decCtrl_w = 11'b11_0000_00100; useRs1_w = 1'b0; end
      OPC_AUIPC:  begin decCtrl_w = 11'b00_0000_11100; useRs1_w = 1'b0; end
      default:    known_w = 1'b0;
    endcase
    if (rd_w == '0) decCtrl_w[2] = 1'b0;
  end

  assign idOk_w    = instrValid_I & (known_w | ~ILLEGAL_AS_NOP);
  assign illegal_O = instrValid_I & ~known_w;

  assign hazard_w = exValid_q & exCtrl_q[0] & (exRd_q != '0) & instrValid_I &
                    ((useRs1_w & (rs1_w == exRd_q)) | (useRs2_w & (rs2_w == exRd_q)));

  // Redirect outranks the load-use stall: the dependent instruction is being dropped anyway.
  assign stall_O  = ~rst_I & (memStall_I | (~redirect_I & hazard_w));
  assign bubble_w = redirect_I | hazard_w | ~idOk_w;

  always_comb begin
    exValid_d = 1'b0;
    exCtrl_d  = '0;
    exRd_d    = '0;
    if (!bubble_w) begin
      exValid_d = 1'b1;
      exCtrl_d  = decCtrl_w;
      exRd_d    = rd_w;
    end
  end

  always_ff @(posedge clk_I) begin
    if (rst_I) begin
      exValid_q  <= 1'b0;  exCtrl_q  <= '0;  exRd_q  <= '0;
      memValid_q <= 1'b0;  memCtrl_q <= '0;  memRd_q <= '0;
      wbValid_q  <= 1'b0;  wbCtrl_q  <= '0;  wbRd_q  <= '0;
    end else if (!memStall_I) begin
      exValid_q  <= exValid_d;   exCtrl_q  <= exCtrl_d;   exRd_q  <= exRd_d;
      memValid_q <= exValid_q;   memCtrl_q <= exCtrl_q;   memRd_q <= exRd_q;
      wbValid_q  <= memValid_q;  wbCtrl_q  <= memCtrl_q;  wbRd_q  <= memRd_q;
    end
  end

  assign exCtrl_O   = exCtrl_q;
  assign exRd_O     = exRd_q;
  assign exValid_O  = exValid_q;
  assign memCtrl_O  = memCtrl_q;
  assign memRd_O    = memRd_q;
  assign memValid_O = memValid_q;
  assign wbCtrl_O   = wbCtrl_q;
  assign wbRd_O     = wbRd_q;
  assign wbValid_O  = wbValid_q;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] stallCnt_q, flushCnt_q, retireCnt_q;

  always_ff @(posedge clk_I) begin
    if (rst_I) begin
      stallCnt_q  <= '0;
      flushCnt_q  <= '0;
      retireCnt_q <= '0;
    end else if (!memStall_I) begin
      if (redirect_I)                stallCnt_q  <= stallCnt_q;
      else if (hazard_w)             stallCnt_q  <= stallCnt_q + 32'd1;
      if (redirect_I)                flushCnt_q  <= flushCnt_q + 32'd1;
      if (wbValid_q)                 retireCnt_q <= retireCnt_q + 32'd1;
    end
  end

  assign stallCnt_O  = stallCnt_q;
  assign flushCnt_O  = flushCnt_q;
  assign retireCnt_O = retireCnt_q;
`else
  assign stallCnt_O  = '0;
  assign flushCnt_O  = '0;
  assign retireCnt_O = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ctrl_pipe_unit : directed self-checking bench for ctrl_pipe_unit       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_ctrl_pipe_unit;

  logic        clk_I = 1'b0;
  logic        rst_I, instrValid_I, redirect_I, memStall_I;
  logic [31:0] instr_I;
  logic        stall_O, illegal_O;
  logic [10:0] exCtrl_O, memCtrl_O, wbCtrl_O;
  logic [4:0]  exRd_O, memRd_O, wbRd_O;
  logic        exValid_O, memValid_O, wbValid_O;
  logic [31:0] stallCnt_O, flushCnt_O, retireCnt_O;

  int total = 0;
  int bad   = 0;

  ctrl_pipe_unit #(.REG_AW(5), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk_I(clk_I), .rst_I(rst_I), .instr_I(instr_I), .instrValid_I(instrValid_I),
    .redirect_I(redirect_I), .memStall_I(memStall_I), .stall_O(stall_O),
    .illegal_O(illegal_O), .exCtrl_O(exCtrl_O), .exRd_O(exRd_O), .exValid_O(exValid_O),
    .memCtrl_O(memCtrl_O), .memRd_O(memRd_O), .memValid_O(memValid_O),
    .wbCtrl_O(wbCtrl_O), .wbRd_O(wbRd_O), .wbValid_O(wbValid_O),
    .stallCnt_O(stallCnt_O), .flushCnt_O(flushCnt_O), .retireCnt_O(retireCnt_O)
  );

  always #5 clk_I = ~clk_I;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b0, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk_I);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [6:0]  opcTab [9];
  logic [10:0] expTab [9];
  logic [31:0] stallBase, flushBase;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    opcTab = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
               7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    expTab = '{11'h215, 11'h012, 11'h024, 11'h134, 11'h040,
               11'h49C, 11'h494, 11'h604, 11'h01C};

    // Reset held two cycles with a LOAD presented in ID
    rst_I = 1'b1; instrValid_I = 1'b1; redirect_I = 1'b0; memStall_I = 1'b0;
    instr_I = mk(7'b0000011, 5'd5, 5'd0, 5'd0);
    step(); step();
    chk("rst_exValid", 32'(exValid_O), 32'd0);
    chk("rst_memValid", 32'(memValid_O), 32'd0);
    chk("rst_wbValid", 32'(wbValid_O), 32'd0);
    chk("rst_exCtrl", 32'(exCtrl_O), 32'd0);
    chk("rst_stall", 32'(stall_O), 32'd0);
    chk("rst_retire", retireCnt_O, 32'd0);
    rst_I = 1'b0;

    // Decode sweep, rd=5, rs1/rs2=x0 so no hazards
    for (int i = 0; i < 9; i++) begin
      instr_I = mk(opcTab[i], 5'd5, 5'd0, 5'd0);
      #1;
      chk("dec_illegal", 32'(illegal_O), 32'd0);
      step();
      chk("dec_exCtrl", 32'(exCtrl_O), 32'(expTab[i]));
      chk("dec_exRd", 32'(exRd_O), 32'd5);
      chk("dec_exValid", 32'(exValid_O), 32'd1);
    end
    chk("dec_memCtrl", 32'(memCtrl_O), 32'h604);
    chk("dec_wbCtrl", 32'(wbCtrl_O), 32'h494);

    // Unknown opcode 0x7F
    instr_I = mk(7'h7F, 5'd5, 5'd0, 5'd0);
    #1;
    chk("ill_flag", 32'(illegal_O), 32'd1);
    step();
    chk("ill_exValid", 32'(exValid_O), 32'd0);
    chk("ill_exCtrl", 32'(exCtrl_O), 32'd0);

    // rd=0 clears regWrite; instrValid=0 inserts a bubble
    instr_I = mk(7'b0110011, 5'd0, 5'd1, 5'd2);
    step();
    chk("rd0_exCtrl", 32'(exCtrl_O), 32'h020);
    instrValid_I = 1'b0;
    step();
    chk("inv_exValid", 32'(exValid_O), 32'd0);
    instrValid_I = 1'b1;

    // Load-use: LW x3 ; ADD x4,x3,x1
    stallBase = stallCnt_O; flushBase = flushCnt_O;
    instr_I = mk(7'b0000011, 5'd3, 5'd0, 5'd0);
    step();
    chk("lu_lw_ex", 32'(exCtrl_O), 32'h215);
    instr_I = mk(7'b0110011, 5'd4, 5'd3, 5'd1);
    #1;
    chk("lu_stall", 32'(stall_O), 32'd1);
    step();
    chk("lu_bubble", 32'(exValid_O), 32'd0);
    chk("lu_memCtrl", 32'(memCtrl_O), 32'h215);
    chk("lu_stall_clr", 32'(stall_O), 32'd0);
    step();
    chk("lu_add_ex", 32'(exCtrl_O), 32'h024);
    chk("lu_add_rd", 32'(exRd_O), 32'd4);
`ifdef CTRL_PERF_CNT_EN
    chk("lu_stallCnt", stallCnt_O, stallBase + 32'd1);
`endif

    // LW x0 then a user of x0: no stall
    instr_I = mk(7'b0000011, 5'd0, 5'd0, 5'd0);
    step();
    chk("lw0_exCtrl", 32'(exCtrl_O), 32'h211);
    instr_I = mk(7'b0110011, 5'd4, 5'd0, 5'd0);
    #1;
    chk("lw0_nostall", 32'(stall_O), 32'd0);
    step();

    // Redirect concurrent with a load-use hazard
    stallBase = stallCnt_O; flushBase = flushCnt_O;
    instr_I = mk(7'b0000011, 5'd3, 5'd0, 5'd0);
    step();
    instr_I = mk(7'b0110011, 5'd4, 5'd3, 5'd1);
    redirect_I = 1'b1;
    #1;
    chk("rd_stall", 32'(stall_O), 32'd0);
    step();
    redirect_I = 1'b0;
    chk("rd_bubble", 32'(exValid_O), 32'd0);
    chk("rd_memCtrl", 32'(memCtrl_O), 32'h215);
`ifdef CTRL_PERF_CNT_EN
    chk("rd_flushCnt", flushCnt_O, flushBase + 32'd1);
    chk("rd_stallCnt", stallCnt_O, stallBase);
`endif

    // Memory hold for three cycles mid-stream
    instr_I = mk(7'b0010011, 5'd6, 5'd0, 5'd0);
    step();
    instr_I = mk(7'b0110011, 5'd7, 5'd0, 5'd0);
    step();
    instr_I = mk(7'b0110111, 5'd8, 5'd0, 5'd0);
    memStall_I = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mh_stall", 32'(stall_O), 32'd1);
      step();
      chk("mh_exCtrl", 32'(exCtrl_O), 32'h024);
      chk("mh_exRd", 32'(exRd_O), 32'd7);
      chk("mh_memRd", 32'(memRd_O), 32'd6);
    end
    memStall_I = 1'b0;
    step();
    chk("mh_res_ex", 32'(exCtrl_O), 32'h604);
    chk("mh_res_mem", 32'(memCtrl_O), 32'h024);
    chk("mh_res_wb", 32'(wbCtrl_O), 32'h134);
    chk("mh_res_wbRd", 32'(wbRd_O), 32'd6);

    // Retire counting: 10 ALU ops from a clean reset
    rst_I = 1'b1;
    step();
    rst_I = 1'b0;
    instr_I = mk(7'b0110011, 5'd5, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) step();
    instrValid_I = 1'b0;
    step(); step();
`ifdef CTRL_PERF_CNT_EN
    chk("ret_early", retireCnt_O, 32'd9);
`else
    chk("ret_tied0", retireCnt_O, 32'd0);
`endif
    step();
`ifdef CTRL_PERF_CNT_EN
    chk("ret_final", retireCnt_O, 32'd10);
`else
    chk("flush_tied0", flushCnt_O, 32'd0);
`endif
    chk("ret_wbValid", 32'(wbValid_O), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
